// File: rtl/video_timing_gen.sv
// Video timing and test-pattern generator.
// Free-running h/v counters produce sync, blanking and data-enable, and a
// selectable 4:4:4 YCbCr test pattern. Every output is registered one cycle
// after the counters. Dropping en lets the current frame finish before idling.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE = 1920,
   parameter int unsigned H_FP     = 88,
   parameter int unsigned H_SYNC   = 44,
   parameter int unsigned H_BP     = 148,
   parameter int unsigned V_ACTIVE = 1080,
   parameter int unsigned V_FP     = 4,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 36
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   output logic        vs_out,
   output logic        hs_out,
   output logic        de_out,
   output logic [7:0]  y_out,
   output logic [7:0]  cb_out,
   output logic [7:0]  cr_out,
   output logic [15:0] frame_cnt
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_ACT_LEN  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_ACT_LEN  = VW'(V_ACTIVE);

   typedef enum logic {StIdle, StRun} state_t;

   state_t          state_q;
   logic [HW-1:0]   h_cnt_q;
   logic [VW-1:0]   v_cnt_q;
   logic [1:0]      pattern_q;

   logic [HW-1:0]   px;
   logic [VW-1:0]   py;
   logic            h_act;
   logic            v_act;
   logic [2:0]      bar;
   logic [15:0]     ramp_sum;
   logic [7:0]      pix_y;
   logic [7:0]      pix_cb;
   logic [7:0]      pix_cr;

   // Run/idle control, raster counters and completed-frame count.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= StIdle;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         frame_cnt <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               h_cnt_q <= '0;
               v_cnt_q <= '0;
               if (en) state_q <= StRun;
            end
            StRun: begin
               if (h_cnt_q == H_LAST) begin
                  h_cnt_q <= '0;
                  if (v_cnt_q == V_LAST) begin
                     v_cnt_q   <= '0;
                     frame_cnt <= frame_cnt + 16'd1;
                     // Stop only on a frame boundary so no frame is truncated.
                     if (!en) state_q <= StIdle;
                  end else begin
                     v_cnt_q <= v_cnt_q + 1'b1;
                  end
               end else begin
                  h_cnt_q <= h_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Pattern select is captured at raster origin so it only changes per frame.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pattern_q <= '0;
      end else if (h_cnt_q == '0 && v_cnt_q == '0) begin
         pattern_q <= pattern_sel;
      end
   end

   // Active-area coordinates and pattern pixel for the current counter position.
   always_comb begin
      // Outside the active area the subtraction wraps to a large value.
      px       = h_cnt_q - H_ACT_BEG;
      py       = v_cnt_q - V_ACT_BEG;
      h_act    = px < H_ACT_LEN;
      v_act    = py < V_ACT_LEN;
      bar      = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         if (px >= HW'(i * BAR_W)) bar = 3'(i);
      end
      ramp_sum = 16'(px >> 3) + 16'd16;
      pix_y    = 8'd128;
      pix_cb   = 8'd128;
      pix_cr   = 8'd128;
      case (pattern_q)
         2'd0: begin
            case (bar)
               3'd0: begin pix_y = 8'd180; pix_cb = 8'd128; pix_cr = 8'd128; end
               3'd1: begin pix_y = 8'd162; pix_cb = 8'd44;  pix_cr = 8'd142; end
               3'd2: begin pix_y = 8'd131; pix_cb = 8'd156; pix_cr = 8'd44;  end
               3'd3: begin pix_y = 8'd112; pix_cb = 8'd72;  pix_cr = 8'd58;  end
               3'd4: begin pix_y = 8'd84;  pix_cb = 8'd184; pix_cr = 8'd198; end
               3'd5: begin pix_y = 8'd65;  pix_cb = 8'd100; pix_cr = 8'd212; end
               3'd6: begin pix_y = 8'd35;  pix_cb = 8'd212; pix_cr = 8'd114; end
               default: begin pix_y = 8'd16; pix_cb = 8'd128; pix_cr = 8'd128; end
            endcase
         end
         2'd1: pix_y = (ramp_sum > 16'd235) ? 8'd235 : ramp_sum[7:0];
         2'd2: pix_y = 8'd128;
         default: pix_y = (px[4] ^ py[4]) ? 8'd235 : 8'd16;
      endcase
   end

   // Registered timing and pixel outputs; all zero while idle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hs_out <= 1'b0;
         vs_out <= 1'b0;
         de_out <= 1'b0;
         y_out  <= '0;
         cb_out <= '0;
         cr_out <= '0;
      end else if (state_q == StRun) begin
         hs_out <= h_cnt_q < H_SYNC_END;
         vs_out <= v_cnt_q >= V_SYNC_END;
         de_out <= h_act && v_act;
         y_out  <= (h_act && v_act) ? pix_y  : 8'd0;
         cb_out <= (h_act && v_act) ? pix_cb : 8'd0;
         cr_out <= (h_act && v_act) ? pix_cr : 8'd0;
      end else begin
         hs_out <= 1'b0;
         vs_out <= 1'b0;
         de_out <= 1'b0;
         y_out  <= '0;
         cb_out <= '0;
         cr_out <= '0;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced raster so several frames fit.
// A raster-position reference model predicts every output cycle.
module tb_video_timing_gen;

   localparam int HA = 160;
   localparam int HF = 4;
   localparam int HS = 3;
   localparam int HB = 5;
   localparam int VA = 40;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FRAME = HT * VT;

   logic        clk;
   logic        rst_b;
   logic        en;
   logic [1:0]  pattern_sel;
   logic        vs_out;
   logic        hs_out;
   logic        de_out;
   logic [7:0]  y_out;
   logic [7:0]  cb_out;
   logic [7:0]  cr_out;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model: 0 idle, 1 armed (run starts next clock), 2 showing raster position m_pos.
   int          m_mode = 0;
   int          m_pos  = 0;
   int          m_pat  = 0;
   logic [15:0] m_frames = '0;
   bit          m_stop = 0;

   video_timing_gen #(
      .H_ACTIVE (HA),
      .H_FP     (HF),
      .H_SYNC   (HS),
      .H_BP     (HB),
      .V_ACTIVE (VA),
      .V_FP     (VF),
      .V_SYNC   (VS),
      .V_BP     (VB)
   ) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .en          (en),
      .pattern_sel (pattern_sel),
      .vs_out      (vs_out),
      .hs_out      (hs_out),
      .de_out      (de_out),
      .y_out       (y_out),
      .cb_out      (cb_out),
      .cr_out      (cr_out),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [42:0] dut_vec();
      return {vs_out, hs_out, de_out, y_out, cb_out, cr_out, frame_cnt};
   endfunction

   // Expected {vs, hs, de, y, cb, cr} for raster position pos under pattern pat.
   function automatic logic [26:0] exp_pix(input int pos, input int pat);
      int   h, v, px, py, y, cb, cr;
      logic hs, vs, de;
      h  = pos % HT;
      v  = pos / HT;
      hs = (h < HS);
      vs = (v >= VS);
      px = h - (HS + HB);
      py = v - (VS + VB);
      de = (px >= 0) && (px < HA) && (py >= 0) && (py < VA);
      y = 0; cb = 0; cr = 0;
      if (de) begin
         cb = 128; cr = 128;
         case (pat)
            0: begin
               case (px / (HA / 8))
                  0: begin y = 180; cb = 128; cr = 128; end
                  1: begin y = 162; cb = 44;  cr = 142; end
                  2: begin y = 131; cb = 156; cr = 44;  end
                  3: begin y = 112; cb = 72;  cr = 58;  end
                  4: begin y = 84;  cb = 184; cr = 198; end
                  5: begin y = 65;  cb = 100; cr = 212; end
                  6: begin y = 35;  cb = 212; cr = 114; end
                  default: begin y = 16; cb = 128; cr = 128; end
               endcase
            end
            1: begin
               y = 16 + px / 8;
               if (y > 235) y = 235;
            end
            2: y = 128;
            default: y = (((px / 16) % 2) != ((py / 16) % 2)) ? 235 : 16;
         endcase
      end
      return {vs, hs, de, 8'(y), 8'(cb), 8'(cr)};
   endfunction

   // Reference model advanced on each clock (asynchronous reset).
   initial begin
      forever begin
         @(posedge clk or negedge rst_b);
         if (!rst_b) begin
            m_mode = 0; m_pos = 0; m_pat = 0; m_frames = '0; m_stop = 0;
         end else begin
            case (m_mode)
               0: if (en) m_mode = 1;
               1: begin m_mode = 2; m_pos = 0; m_pat = int'(pattern_sel); end
               default: begin
                  if (m_stop) begin
                     m_stop = 0;
                     m_mode = en ? 1 : 0;
                  end else begin
                     m_pos = (m_pos == FRAME - 1) ? 0 : m_pos + 1;
                     if (m_pos == 0) m_pat = int'(pattern_sel);
                     if (m_pos == FRAME - 1) begin
                        m_frames++;
                        m_stop = !en;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Per-cycle comparison plus per-frame timing totals.
   initial begin
      int   n_de, n_hs, n_vsl;
      logic prev_de;
      logic [26:0] e;
      n_de = 0; n_hs = 0; n_vsl = 0; prev_de = 1'b0;
      forever begin
         @(negedge clk);
         e = (m_mode == 2) ? exp_pix(m_pos, m_pat) : 27'd0;
         check("cycle", 64'(dut_vec()), 64'({e, m_frames}));
         if (prev_de && !de_out) check("post_de_data", 64'({y_out, cb_out, cr_out}), 64'd0);
         prev_de = de_out;
         if (m_mode == 2) begin
            if (m_pos == 0) begin n_de = 0; n_hs = 0; n_vsl = 0; end
            if (de_out) n_de++;
            if (hs_out) n_hs++;
            if (!vs_out) n_vsl++;
            if (m_pos == FRAME - 1) begin
               check("frame_de", 64'(n_de), 64'(HA * VA));
               check("frame_hs", 64'(n_hs), 64'(HS * VT));
               check("frame_vs_low", 64'(n_vsl), 64'(VS * HT));
            end
         end
      end
   end

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 2 * FRAME && m_mode != 0; i++) step(1);
      check(tag, 64'(m_mode), 64'd0);
      check({tag, "_out"}, 64'({vs_out, hs_out, de_out, y_out, cb_out, cr_out}), 64'd0);
   endtask

   initial begin
      logic [15:0] fc0;
      rst_b = 1'b0; en = 1'b0; pattern_sel = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", 64'(dut_vec()), 64'd0);
      rst_b = 1'b1;
      step(5);
      check("idle_out", 64'(dut_vec()), 64'd0);

      // Bars, then checkerboard with a mid-frame switch to grey.
      en = 1'b1; pattern_sel = 2'd0;
      step(FRAME / 2);
      pattern_sel = 2'd3;
      step(FRAME);
      pattern_sel = 2'd2;
      step(FRAME / 2 + 100);

      // Drop enable mid-frame: the frame must complete, then idle.
      fc0 = m_frames;
      en = 1'b0; pattern_sel = 2'd1;
      wait_idle("drain1");
      check("drain_fc", 64'(frame_cnt), 64'(fc0 + 16'd1));
      step(20);
      check("idle_hold", 64'({vs_out, hs_out, de_out, y_out, cb_out, cr_out}), 64'd0);

      // Ramp, then asynchronous reset mid-frame.
      en = 1'b1;
      step(FRAME / 2);
      #2 rst_b = 1'b0;
      #1;
      check("rst_abort", 64'(dut_vec()), 64'd0);
      step(2);
      rst_b = 1'b1;
      for (int i = 0; i < 8 && m_mode != 2; i++) step(1);
      check("first_vs_hs", 64'({vs_out, hs_out}), 64'(2'b01));

      // Random pattern and enable changes.
      repeat (20) begin
         step(int'($urandom_range(200, 1500)));
         pattern_sel = 2'($urandom);
         en = ($urandom_range(0, 3) != 0);
      end
      en = 1'b0;
      wait_idle("drain2");
      step(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
